control_bomba_agua: RTL and testbench

//  Mealy FSM controlling two water pumps (B1, B2) that fill one tank.
//  I=1: level below the low mark, so one pump runs. The pumps alternate

---
 rtl/control_bomba_agua_pkg.sv | 13 +
 rtl/control_bomba_agua.sv | 57 +++++
 tb/tb_control_bomba_agua.sv | 132 +++++++++++++
 3 files changed

// File: rtl/control_bomba_agua_pkg.sv
// Shared definitions for the two-pump tank fill controller.
`timescale 1us/1ns
package control_bomba_agua_pkg;

  // Encodings match the original codebase so existing waveforms still decode.
  typedef enum logic [1:0] {
    NEXT1 = 2'd0,
    RUN1  = 2'd1,
    NEXT2 = 2'd2,
    RUN2  = 2'd3
  } state_t;

endpackage

// File: rtl/control_bomba_agua.sv
// Mealy controller for two alternating water pumps; S (critical) overrides I (low level).
`timescale 1us/1ns
module control_bomba_agua
  import control_bomba_agua_pkg::*;
(
  input  logic I,
  input  logic S,
  output logic B1,
  output logic B2,
  input  logic clk,
  input  logic reset_n
);

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (reset_n) state <= NEXT1;
    else         state <= state_nxt;
  end

  // if/else on the inputs keeps pumps off when sensors are still undriven (X).
  always_comb begin
    state_nxt = state;
    B1        = 1'b0;
    B2        = 1'b0;
    if (!reset_n) begin
      case (state)
        NEXT1, RUN1: begin
          if (S) begin
            B1        = 1'b1;
            B2        = 1'b1;
            state_nxt = RUN1;
          end else if (I) begin
            B1        = 1'b1;
            state_nxt = RUN1;
          end else if (state == RUN1) begin
            state_nxt = NEXT2;
          end
        end
        NEXT2, RUN2: begin
          if (S) begin
            B1        = 1'b1;
            B2        = 1'b1;
            state_nxt = RUN2;
          end else if (I) begin
            B2        = 1'b1;
            state_nxt = RUN2;
          end else if (state == RUN2) begin
            state_nxt = NEXT1;
          end
        end
        default: state_nxt = NEXT1;
      endcase
    end
  end

endmodule

// File: tb/tb_control_bomba_agua.sv
// Directed scoreboard bench for control_bomba_agua: expectations queued on drive, checked on output.
`timescale 1us/1ns
module tb_control_bomba_agua;

  logic clk;
  logic reset_n;
  logic I;
  logic S;
  logic B1;
  logic B2;

  typedef struct {
    string      tag;
    logic [1:0] pumps;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  control_bomba_agua dut (
    .I       (I),
    .S       (S),
    .B1      (B1),
    .B2      (B2),
    .clk     (clk),
    .reset_n (reset_n)
  );

  // Clock starts low and toggles every 1 us (2 us period).
  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  task automatic check_out();
    exp_t       e;
    logic [1:0] got;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_empty got=none want=entry");
      return;
    end
    e   = sb.pop_front();
    got = {B1, B2};
    n_cmp++;
    assert (got === e.pumps)
    else begin
      n_bad++;
      $error("FAIL %s got B1B2=%b want B1B2=%b", e.tag, got, e.pumps);
    end
  endtask

  // Drive inputs mid-cycle, then check the Mealy outputs before the next rising edge.
  task automatic step(input logic r, input logic i, input logic s,
                      input logic [1:0] want, input string tag);
    exp_t e;
    @(negedge clk);
    reset_n = r;
    I       = i;
    S       = s;
    e.tag   = tag;
    e.pumps = want;
    sb.push_back(e);
    #0.25;
    check_out();
  endtask

  initial begin
    int t_ns;
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b1;
    I       = 1'b0;
    S       = 1'b0;

    @(posedge clk);
    t_ns = int'($realtime * 1000.0);
    n_cmp++;
    assert (t_ns === 1000)
    else begin
      n_bad++;
      $error("FAIL first_rise got=%0d ns want=1000 ns", t_ns);
    end

    step(1'b1, 1'b0, 1'b0, 2'b00, "reset_idle");
    step(1'b0, 1'bx, 1'bx, 2'b00, "x_inputs_off");
    step(1'b0, 1'b1, 1'b0, 2'b10, "fill1_start");
    step(1'b0, 1'b1, 1'b0, 2'b10, "fill1_hold_a");
    step(1'b0, 1'b1, 1'b0, 2'b10, "fill1_hold_b");
    step(1'b0, 1'b1, 1'b0, 2'b10, "fill1_hold_c");
    step(1'b0, 1'b0, 1'b0, 2'b00, "fill1_end");
    step(1'b0, 1'b1, 1'b0, 2'b01, "alt_to_b2");
    step(1'b0, 1'b0, 1'b0, 2'b00, "fill2_end");
    step(1'b0, 1'b1, 1'b0, 2'b10, "alt_to_b1");
    step(1'b0, 1'b1, 1'b1, 2'b11, "crit_in_run1");
    step(1'b0, 1'b1, 1'b0, 2'b10, "crit_off_run1");
    step(1'b0, 1'b0, 1'b0, 2'b00, "run1_done");
    step(1'b0, 1'b1, 1'b0, 2'b01, "run2_start");
    step(1'b0, 1'b1, 1'b1, 2'b11, "crit_in_run2");
    step(1'b0, 1'b1, 1'b0, 2'b01, "crit_off_run2");
    step(1'b1, 1'b1, 1'b0, 2'b00, "reset_mid_fill");
    step(1'b0, 1'b1, 1'b0, 2'b10, "after_reset_b1");
    step(1'b0, 1'b0, 1'b1, 2'b11, "crit_only_run1");
    step(1'b0, 1'b0, 1'b0, 2'b00, "crit_only_end1");
    step(1'b0, 1'b0, 1'b1, 2'b11, "crit_idle_next2");
    step(1'b0, 1'b0, 1'b0, 2'b00, "crit_only_end2");
    step(1'b0, 1'b0, 1'b0, 2'b00, "idle_stay_next1");
    step(1'b0, 1'b1, 1'b0, 2'b10, "next1_confirm");

    // Sub-cycle glitch on I must show up on the outputs without waiting for a clock.
    @(negedge clk);
    I = 1'b0;
    S = 1'b0;
    sb.push_back('{tag: "glitch_low", pumps: 2'b10});
    #0.1;
    I = 1'b1;
    #0.1;
    check_out();

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
